display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan_pkg.sv | 39 +++
 rtl/display_scan_bcd_to_seg.sv | 28 ++
 rtl/display_scan.sv | 166 ++++++++++++++++
 tb/tb_display_scan.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/display_scan_pkg.sv
// Shared definitions for the multiplexed 3-digit display scanner:
// scan state encoding, digit-enable patterns and 7-segment constants.
package display_scan_pkg;

    typedef enum logic [1:0] {
        S_ONES = 2'd0,
        S_TENS = 2'd1,
        S_MIN  = 2'd2
    } scan_state_t;

    // Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [2:0] AN_OFF = 3'b111;

    // Active-low one-hot digit enable {min,tens,ones} for a scan slot.
    function automatic logic [2:0] an_for_state(input scan_state_t st);
        logic [2:0] v;
        case (st)
            S_ONES:  v = 3'b110;
            S_TENS:  v = 3'b101;
            S_MIN:   v = 3'b011;
            default: v = AN_OFF;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/display_scan_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 are not valid BCD and render as a dash.
module bcd_to_seg
    import display_scan_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Plain lookup; blanking is decided by the caller.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scanner for a 3-digit M:SS display with a blinking colon.
//
//   state  | meaning
//   S_ONES | ones-of-seconds digit lit; entered on frame capture
//   S_TENS | tens-of-seconds digit lit (blanked if minutes and tens are 0)
//   S_MIN  | minutes digit lit (blanked if minutes is 0); reset state
//
// A frame is captured into shadow registers on the tick that enters S_ONES,
// so all three digits of one frame come from the same count. Outputs are
// registered and change on the clock that ends a tick cycle.
module display_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 167
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] minutes,
    input  logic [3:0] seconds_tens,
    input  logic [3:0] seconds_ones,
    input  logic       mag_on,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       colon
);

    import display_scan_pkg::*;

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [PW-1:0] r_presc;
    logic          w_tick;

    scan_state_t   r_state;
    scan_state_t   w_state_nxt;
    logic          w_capture;

    logic [3:0]    r_min;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic [3:0]    w_min_v;
    logic [3:0]    w_tens_v;
    logic [3:0]    w_ones_v;

    logic [3:0]    w_digit;
    logic          w_blank;
    logic [6:0]    w_seg_dec;
    logic [6:0]    w_seg_nxt;
    logic [2:0]    w_an_nxt;

    logic [BW-1:0] r_blink;

    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

    // Slot prescaler: free-running 0..SCAN_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Scan state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_MIN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, frame-capture strobe and the digit to show in the next slot.
    // The digit values seen here are post-capture, so the ones slot that
    // opens a frame already shows the freshly captured count.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_ONES:  w_state_nxt = S_TENS;
                S_TENS:  w_state_nxt = S_MIN;
                default: begin
                    w_state_nxt = S_ONES;
                    w_capture   = 1'b1;
                end
            endcase
        end

        w_min_v  = w_capture ? minutes      : r_min;
        w_tens_v = w_capture ? seconds_tens : r_tens;
        w_ones_v = w_capture ? seconds_ones : r_ones;

        w_digit = w_ones_v;
        w_blank = 1'b0;
        case (w_state_nxt)
            S_TENS: begin
                w_digit = w_tens_v;
                w_blank = (w_min_v == 4'd0) && (w_tens_v == 4'd0);
            end
            S_MIN: begin
                w_digit = w_min_v;
                w_blank = (w_min_v == 4'd0);
            end
            default: begin
                w_digit = w_ones_v;
                w_blank = 1'b0;
            end
        endcase

        w_an_nxt = an_for_state(w_state_nxt);
    end

    bcd_to_seg u_bcd_to_seg (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

    assign w_seg_nxt = w_blank ? SEG_BLANK : w_seg_dec;

    // Shadow registers: one snapshot of the count per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min  <= 4'd0;
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (w_capture) begin
            r_min  <= minutes;
            r_tens <= seconds_tens;
            r_ones <= seconds_ones;
        end
    end

    // Digit drive: segments and enable change together, once per slot.
    // A blanked digit keeps its enable low so every slot has equal duty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (w_tick) begin
            an  <= w_an_nxt;
            seg <= w_seg_nxt;
        end
    end

    // Colon: steady while idle, blinks on slot ticks while the magnetron runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colon   <= 1'b0;
            r_blink <= '0;
        end else if (!mag_on) begin
            colon   <= 1'b1;
            r_blink <= '0;
        end else if (w_tick) begin
            if (r_blink == BW'(BLINK_DIV - 1)) begin
                colon   <= ~colon;
                r_blink <= '0;
            end else begin
                r_blink <= r_blink + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with SCAN_DIV=4, BLINK_DIV=2.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_display_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] minutes = 4'd1;
    logic [3:0] seconds_tens = 4'd2;
    logic [3:0] seconds_ones = 4'd5;
    logic       mag_on = 1'b0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       colon;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PD = 7'b0111111;

    display_scan #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .minutes      (minutes),
        .seconds_tens (seconds_tens),
        .seconds_ones (seconds_ones),
        .mag_on       (mag_on),
        .seg          (seg),
        .an           (an),
        .colon        (colon)
    );

    always #5 clk = ~clk;

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic slot(input string tag, input logic [2:0] exp_an, input logic [6:0] exp_seg);
        chk({tag, ".an"}, {4'b0, an}, {4'b0, exp_an});
        chk({tag, ".seg"}, seg, exp_seg);
    endtask

    initial begin
        logic found;
        logic exp_colon;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        slot("rst0", 3'b111, PB);
        chk("rst0.colon", {6'b0, colon}, 7'd0);
        clk_n(2);
        slot("rst0_held", 3'b111, PB);
        @(negedge clk) rst = 1'b0;

        // Frame 1: 1:25. No digit pulse before the first tick.
        clk_n(3);
        slot("prelude", 3'b111, PB);
        clk_n(1);
        slot("f1.ones", 3'b110, P5);
        chk("idle.colon", {6'b0, colon}, 7'd1);
        clk_n(3);
        slot("f1.ones_hold", 3'b110, P5);
        clk_n(1);
        slot("f1.tens", 3'b101, P2);
        clk_n(4);
        slot("f1.min", 3'b011, P1);
        clk_n(4);
        slot("f2.ones", 3'b110, P5);

        // 0:07 applied mid-frame; current frame keeps 1:25.
        minutes = 4'd0; seconds_tens = 4'd0; seconds_ones = 4'd7;
        clk_n(4);
        slot("f2.tens", 3'b101, P2);
        clk_n(4);
        slot("f2.min", 3'b011, P1);
        clk_n(4);
        slot("f3.ones", 3'b110, P7);
        clk_n(4);
        slot("f3.tens_blank", 3'b101, PB);
        clk_n(4);
        slot("f3.min_blank", 3'b011, PB);

        // 0:30: minutes blanked, tens shown, ones zero shown.
        minutes = 4'd0; seconds_tens = 4'd3; seconds_ones = 4'd0;
        clk_n(4);
        slot("f4.ones", 3'b110, P0);
        clk_n(4);
        slot("f4.tens", 3'b101, P3);
        clk_n(4);
        slot("f4.min_blank", 3'b011, PB);

        // Ones 4 -> 3 during the tens slot.
        seconds_ones = 4'd4;
        clk_n(4);
        slot("f5.ones", 3'b110, P4);
        clk_n(2);
        slot("f5.ones_mid", 3'b110, P4);
        clk_n(2);
        slot("f5.tens", 3'b101, P3);
        seconds_ones = 4'd3;
        clk_n(2);
        slot("f5.tens_mid", 3'b101, P3);
        clk_n(2);
        slot("f5.min", 3'b011, PB);
        clk_n(4);
        slot("f6.ones", 3'b110, P3);

        // Invalid BCD on minutes and ones renders as a dash.
        minutes = 4'd10; seconds_ones = 4'd12;
        clk_n(4);
        slot("f6.tens", 3'b101, P3);
        clk_n(4);
        slot("f6.min", 3'b011, PB);
        clk_n(4);
        slot("f7.ones_dash", 3'b110, PD);
        clk_n(4);
        slot("f7.tens", 3'b101, P3);
        clk_n(4);
        slot("f7.min_dash", 3'b011, PD);

        // Colon blink: toggles every 2 ticks, starting from 1.
        mag_on = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            clk_n(4);
            exp_colon = ((k / 2) % 2) == 0;
            chk($sformatf("blink.t%0d", k), {6'b0, colon}, {6'b0, exp_colon});
        end
        mag_on = 1'b0;
        clk_n(1);
        chk("blink.drop", {6'b0, colon}, 7'd1);
        // Blink counter must have been cleared by the drop.
        mag_on = 1'b1;
        clk_n(3);
        chk("blink.restart1", {6'b0, colon}, 7'd1);
        clk_n(4);
        chk("blink.restart2", {6'b0, colon}, 7'd0);
        mag_on = 1'b0;
        clk_n(1);
        chk("blink.drop2", {6'b0, colon}, 7'd1);

        // Reset in the middle of a tens slot.
        minutes = 4'd1; seconds_tens = 4'd2; seconds_ones = 4'd5;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            clk_n(1);
            if (an == 3'b101) found = 1'b1;
        end
        chk("find_tens", {6'b0, found}, 7'd1);
        clk_n(1);
        #2 rst = 1'b1;
        #1;
        slot("rst_mid", 3'b111, PB);
        chk("rst_mid.colon", {6'b0, colon}, 7'd0);
        @(negedge clk) rst = 1'b0;
        clk_n(3);
        slot("post_rst.prelude", 3'b111, PB);
        // First digit becomes visible in the fifth cycle after release.
        clk_n(1);
        slot("post_rst.ones", 3'b110, P5);
        clk_n(4);
        slot("post_rst.tens", 3'b101, P2);
        clk_n(4);
        slot("post_rst.min", 3'b011, P1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
